// File: rtl/counter_pkg.sv
// Shared constants and helpers for carry-chained counter stages.
// Multi-stage wrappers import this so every stage agrees on the default width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Terminal count of a default-width stage (all ones).
  localparam logic [DEFAULT_WIDTH-1:0] CNT_MAX = {DEFAULT_WIDTH{1'b1}};

  // A stage carries out only when enabled at its terminal count and not in reset.
  function automatic logic carry_out(input logic rst_n, input logic cin, input logic at_max);
    return rst_n & cin & at_max;
  endfunction

endpackage

// File: rtl/counter_stage.sv
// WIDTH-bit count register with synchronous active-low reset and enable,
// plus the all-ones detect used to build the carry to the next stage.
module counter_stage
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;

  // Modulo-2^WIDTH increment; the adder simply drops the carry bit.
  always_comb begin
    q_next = q_reg;
    if (en) begin
      q_next = q_reg + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q      = q_reg;
  assign at_max = (q_reg == MAX);

endmodule

// File: rtl/counter_top_8b.sv
// Cascadable counter stage: counts on each edge where cin is high and raises
// cout combinationally in the cycle whose edge wraps the count to zero.
module counter_top_8b
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cin,
  output logic             cout,
  output logic [WIDTH-1:0] q
);

  logic at_max;

  counter_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (cin),
    .q      (q),
    .at_max (at_max)
  );

  // Gating with rst_n keeps a reset edge at all-ones from looking like a wrap downstream.
  assign cout = carry_out(rst_n, cin, at_max);

endmodule

// File: tb/tb_counter_top_8b.sv
// Self-checking bench for counter_top_8b: directed scenarios plus random cin/rst_n
// checked every cycle against an arithmetic reference of the count.
module tb_counter_top_8b;
  import counter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cin;
  logic       cout;
  logic [7:0] q;

  int tests;
  int fails;
  int model_q;
  int cout_seen;
  int last_cout_q;
  bit check_en;

  counter_top_8b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cin   (cin),
    .cout  (cout),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count of accepted strobes since the last reset, modulo 256.
  always @(posedge clk) begin
    if (rst_n !== 1'b1) model_q = 0;
    else if (cin === 1'b1) model_q = (model_q + 1) % 256;
  end

  // Per-cycle compare, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      int exp_cout;
      exp_cout = (rst_n === 1'b1 && cin === 1'b1 && model_q == 255) ? 1 : 0;
      tests++;
      if (q !== 8'(model_q)) begin
        fails++;
        $display("FAIL q_model: got %0d, expected %0d at %0t", q, model_q, $time);
      end
      tests++;
      if (cout !== 1'(exp_cout)) begin
        fails++;
        $display("FAIL cout_model: got %b, expected %0d (q=%0d) at %0t", cout, exp_cout, q, $time);
      end
      if (cout === 1'b1) begin
        cout_seen++;
        last_cout_q = int'(q);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end else begin
      $display("[TB] ok %s = %0d", name, actual);
    end
  endtask

  // Apply inputs for one cycle, then step just past the edge that samples them.
  task automatic tick(input logic r, input logic c);
    rst_n = r;
    cin   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  initial begin
    tests = 0; fails = 0; model_q = 0; cout_seen = 0; last_cout_q = -1; check_en = 0;
    rst_n = 1'b0;
    cin   = 1'b1;

    // Reset held with cin high.
    tick(1'b0, 1'b1);
    check_en = 1;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("reset_q", int'(q), 0);
    check("reset_cout", int'(cout), 0);
    tick(1'b1, 1'b1);
    check("release_q", int'(q), 1);

    // Sparse strobes: 1 of every 6 cycles.
    do_reset();
    cout_seen = 0;
    for (int p = 0; p < 10; p++) begin
      tick(1'b1, 1'b1);
      for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    end
    check("sparse_q", int'(q), 10);
    check("sparse_cout_count", cout_seen, 0);

    // Wrap-around with spaced pulses.
    do_reset();
    cout_seen = 0; last_cout_q = -1;
    for (int p = 1; p <= 300; p++) begin
      tick(1'b1, 1'b1);
      if (p == 256) check("wrap_q_after_256", int'(q), 0);
      for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    end
    check("wrap_cout_count", cout_seen, 1);
    check("wrap_cout_at_q", last_cout_q, int'(CNT_MAX));
    check("wrap_final_q", int'(q), 44);
    for (int k = 0; k < 200; k++) tick(1'b1, 1'b0);
    check("wrap_idle_q", int'(q), 44);

    // Continuous count through one wrap.
    do_reset();
    cout_seen = 0; last_cout_q = -1;
    for (int k = 0; k < 257; k++) tick(1'b1, 1'b1);
    check("cont_q", int'(q), 1);
    check("cont_cout_count", cout_seen, 1);
    check("cont_cout_at_q", last_cout_q, 255);

    // Hold at max, then same-cycle carry on cin.
    do_reset();
    for (int k = 0; k < 255; k++) tick(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    check("hold_q", int'(q), 255);
    check("hold_cout", int'(cout), 0);
    cin = 1'b1;
    #1;
    check("hold_cin_cout", int'(cout), 1);

    // Reset priority at all-ones.
    rst_n = 1'b0;
    #1;
    check("rstprio_cout", int'(cout), 0);
    @(posedge clk);
    #1;
    check("rstprio_q", int'(q), 0);

    // Random cin with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      tick(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0));
    end

    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
